// File: rtl/int_issue_queue.sv
// Integer issue queue: compacting, age-ordered reservation station.
// Entry 0 holds the oldest op; occupied entries are contiguous from index 0.
// Each entry waits for both source operands, which are filled either at
// dispatch time or by a later CDB broadcast. The oldest ready entry is
// presented on issue_*; a granted issue removes it, and younger entries shift
// down one slot at the next edge.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   dispatch_en/op/rd_tag new op request, opcode (opaque), destination tag
//   dispatch_rs1/rs2      source operands, packed {tag, valid, data}
//   cdb_input             result broadcast {tag, valid, data, flags[2:0]}
//   issue_int             grant from the issue unit
//   ready_int             some entry has both operands valid
//   issue_op/rd_tag/rs1_data/rs2_data  fields of the oldest ready entry
//   queue_full, count     occupancy
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        dispatch_en,
  input  logic [3:0]                  dispatch_op,
  input  logic [TAG_W-1:0]            dispatch_rd_tag,
  input  logic [TAG_W+DATA_W:0]       dispatch_rs1,
  input  logic [TAG_W+DATA_W:0]       dispatch_rs2,
  input  logic [TAG_W+DATA_W+3:0]     cdb_input,
  input  logic                        issue_int,
  output logic                        ready_int,
  output logic [3:0]                  issue_op,
  output logic [TAG_W-1:0]            issue_rd_tag,
  output logic [DATA_W-1:0]           issue_rs1_data,
  output logic [DATA_W-1:0]           issue_rs2_data,
  output logic                        queue_full,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              busy;
    logic [3:0]        op;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  t1;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic [TAG_W-1:0]  t2;
    logic              v2;
    logic [DATA_W-1:0] d2;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t woke  [DEPTH+1];
  entry_t ent_d [DEPTH];
  entry_t disp_e;
  entry_t sel_e;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  sel;
  logic              any_ready;
  logic              fire;
  logic              accept;

  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_v;
  logic [DATA_W-1:0] cdb_data;
  logic              unused_cdb_flags;

  assign cdb_tag          = cdb_input[DATA_W+4 +: TAG_W];
  assign cdb_v            = cdb_input[DATA_W+3];
  assign cdb_data         = cdb_input[3 +: DATA_W];
  assign unused_cdb_flags = ^cdb_input[2:0];

  // Full is judged on the registered count, so an issue in the same cycle
  // cannot make room for a dispatch.
  assign queue_full = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign accept     = dispatch_en & ~queue_full;

  // Oldest ready entry; scanning from the top leaves the lowest index.
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_q[i].busy && ent_q[i].v1 && ent_q[i].v2) begin
        any_ready = 1'b1;
        sel       = IDX_W'(i);
      end
    end
  end

  assign fire      = issue_int & any_ready;
  assign ready_int = any_ready;
  assign sel_e     = ent_q[sel];

  assign issue_op       = any_ready ? sel_e.op : '0;
  assign issue_rd_tag   = any_ready ? sel_e.rd : '0;
  assign issue_rs1_data = any_ready ? sel_e.d1 : '0;
  assign issue_rs2_data = any_ready ? sel_e.d2 : '0;

  // Incoming op, with a same-cycle CDB match captured on the way in.
  always_comb begin
    disp_e      = '0;
    disp_e.busy = 1'b1;
    disp_e.op   = dispatch_op;
    disp_e.rd   = dispatch_rd_tag;
    disp_e.t1   = dispatch_rs1[DATA_W+1 +: TAG_W];
    disp_e.v1   = dispatch_rs1[DATA_W];
    disp_e.d1   = dispatch_rs1[DATA_W-1:0];
    disp_e.t2   = dispatch_rs2[DATA_W+1 +: TAG_W];
    disp_e.v2   = dispatch_rs2[DATA_W];
    disp_e.d2   = dispatch_rs2[DATA_W-1:0];
    if (cdb_v && !disp_e.v1 && disp_e.t1 == cdb_tag) begin
      disp_e.v1 = 1'b1;
      disp_e.d1 = cdb_data;
    end
    if (cdb_v && !disp_e.v2 && disp_e.t2 == cdb_tag) begin
      disp_e.v2 = 1'b1;
      disp_e.d2 = cdb_data;
    end
  end

  // Wakeup is applied before the shift so a captured value follows its entry
  // into the new slot. woke[DEPTH] is the empty slot shifted into the top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cdb_v && ent_q[i].busy) begin
        if (!ent_q[i].v1 && ent_q[i].t1 == cdb_tag) begin
          woke[i].v1 = 1'b1;
          woke[i].d1 = cdb_data;
        end
        if (!ent_q[i].v2 && ent_q[i].t2 == cdb_tag) begin
          woke[i].v2 = 1'b1;
          woke[i].d2 = cdb_data;
        end
      end
    end
    woke[DEPTH] = '0;

    wr_idx = count_q - CNT_W'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (fire && IDX_W'(i) >= sel) ? woke[i+1] : woke[i];
      if (accept && CNT_W'(i) == wr_idx) ent_d[i] = disp_e;
    end

    count_d = count_q + CNT_W'(accept) - CNT_W'(fire);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: a table of per-cycle stimulus with the expected
// post-edge outputs, driven through a scoreboard queue, followed by a
// hand-written asynchronous-reset sequence.
module tb_int_issue_queue;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        dispatch_en;
  logic [3:0]  dispatch_op;
  logic [5:0]  dispatch_rd_tag;
  logic [38:0] dispatch_rs1;
  logic [38:0] dispatch_rs2;
  logic [41:0] cdb_input;
  logic        issue_int;
  logic        ready_int;
  logic [3:0]  issue_op;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic        queue_full;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .dispatch_en(dispatch_en), .dispatch_op(dispatch_op),
    .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2),
    .cdb_input(cdb_input), .issue_int(issue_int),
    .ready_int(ready_int), .issue_op(issue_op), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .queue_full(queue_full), .count(count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rdy;
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  cnt;
    logic        full;
  } exp_t;

  typedef struct {
    logic        en;
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [38:0] rs1;
    logic [38:0] rs2;
    logic        cv;
    logic [5:0]  ctag;
    logic [31:0] cdata;
    logic        iss;
    exp_t        e;
  } vec_t;

  vec_t vt [40];
  int   nv = 0;
  exp_t sb [$];

  function automatic logic [38:0] o(input logic [5:0] t, input logic v, input logic [31:0] d);
    return {t, v, d};
  endfunction

  task automatic add(input logic en, input logic [3:0] op, input logic [5:0] rd,
                     input logic [38:0] rs1, input logic [38:0] rs2,
                     input logic cv, input logic [5:0] ctag, input logic [31:0] cdata,
                     input logic iss,
                     input logic r, input logic [3:0] eop, input logic [5:0] erd,
                     input logic [31:0] ed1, input logic [31:0] ed2,
                     input logic [2:0] ecnt, input logic efull);
    vt[nv].en = en; vt[nv].op = op; vt[nv].rd = rd;
    vt[nv].rs1 = rs1; vt[nv].rs2 = rs2;
    vt[nv].cv = cv; vt[nv].ctag = ctag; vt[nv].cdata = cdata; vt[nv].iss = iss;
    vt[nv].e.rdy = r; vt[nv].e.op = eop; vt[nv].e.rd = erd;
    vt[nv].e.d1 = ed1; vt[nv].e.d2 = ed2; vt[nv].e.cnt = ecnt; vt[nv].e.full = efull;
    nv++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " ready_int"},  64'(ready_int),      64'(e.rdy));
    check({tag, " issue_op"},   64'(issue_op),       64'(e.op));
    check({tag, " issue_rd"},   64'(issue_rd_tag),   64'(e.rd));
    check({tag, " rs1_data"},   64'(issue_rs1_data), 64'(e.d1));
    check({tag, " rs2_data"},   64'(issue_rs2_data), 64'(e.d2));
    check({tag, " count"},      64'(count),          64'(e.cnt));
    check({tag, " queue_full"}, 64'(queue_full),     64'(e.full));
  endtask

  task automatic drive(input logic en, input logic [3:0] op, input logic [5:0] rd,
                       input logic [38:0] rs1, input logic [38:0] rs2,
                       input logic cv, input logic [5:0] ctag, input logic [31:0] cdata,
                       input logic iss);
    dispatch_en     = en;
    dispatch_op     = op;
    dispatch_rd_tag = rd;
    dispatch_rs1    = rs1;
    dispatch_rs2    = rs2;
    cdb_input       = {ctag, cv, cdata, 3'($urandom_range(7))};
    issue_int       = iss;
  endtask

  exp_t z;
  exp_t got;

  initial begin
    z = '{rdy: 1'b0, op: 4'h0, rd: 6'h0, d1: 32'h0, d2: 32'h0, cnt: 3'd0, full: 1'b0};

    //   en op rd     rs1                   rs2                   cv ctag  cdata    iss | r op rd    d1       d2       cnt f
    add(1, 3, 6'h0A, o(6'h01,1,32'h11),     o(6'h02,1,32'h22),    0, 0,    0,       0,   1, 3, 6'h0A, 32'h11,  32'h22,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    add(1, 5, 6'h10, o(6'h0B,0,32'hDEAD),   o(6'h03,1,32'h33),    0, 0,    0,       0,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    1, 6'h0B,32'h55,  0,   1, 5, 6'h10, 32'h55,  32'h33,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    add(1, 6, 6'h11, o(6'h04,1,32'h44),     o(6'h0C,0,32'hBEEF),  1, 6'h0C,32'h77,  0,   1, 6, 6'h11, 32'h44,  32'h77,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    // older entry waiting, younger ready: younger issues, older compacts down
    add(1, 1, 6'h01, o(6'h0D,0,32'h0),      o(6'h05,1,32'h05),    0, 0,    0,       0,   0, 0, 0,     0,       0,       1, 0);
    add(1, 2, 6'h02, o(6'h06,1,32'h66),     o(6'h07,1,32'h77),    0, 0,    0,       0,   1, 2, 6'h02, 32'h66,  32'h77,  2, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    1, 6'h0D,32'hDD,  0,   1, 1, 6'h01, 32'hDD,  32'h05,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    // fill to DEPTH, then dispatch while full (with and without issue)
    for (int k = 1; k <= 4; k++)
      add(1, 4'(k), 6'(k), o(6'(k),1,32'h100+k), o(6'(k),1,32'h200+k), 0, 0, 0, 0,
          1, 1, 6'h01, 32'h101, 32'h201, 3'(k), k == 4);
    add(1, 5, 6'h05, o(6'h05,1,32'h105),    o(6'h05,1,32'h205),   0, 0,    0,       0,   1, 1, 6'h01, 32'h101, 32'h201, 4, 1);
    add(1, 5, 6'h05, o(6'h05,1,32'h105),    o(6'h05,1,32'h205),   0, 0,    0,       1,   1, 2, 6'h02, 32'h102, 32'h202, 3, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   1, 3, 6'h03, 32'h103, 32'h203, 2, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   1, 4, 6'h04, 32'h104, 32'h204, 1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    // issue with nothing ready; CDB must not touch valid operands or act when invalid
    add(1, 7, 6'h20, o(6'h08,0,32'h0),      o(6'h09,1,32'h09),    0, 0,    0,       0,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    1, 6'h09,32'hBAD, 0,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    0, 6'h08,32'h99,  0,   0, 0, 0,     0,       0,       1, 0);
    add(0, 0, 0,     0,                     0,                    1, 6'h08,32'h88,  0,   1, 7, 6'h20, 32'h88,  32'h09,  1, 0);
    // dispatch and issue together: new op lands in the slot vacated by the shift
    add(1, 8, 6'h31, o(6'h0A,1,32'hA1),     o(6'h0B,1,32'hB1),    0, 0,    0,       1,   1, 8, 6'h31, 32'hA1,  32'hB1,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);
    // wakeup of an entry that is shifting down in the same cycle
    add(1, 9, 6'h40, o(6'h01,1,32'h1),      o(6'h02,1,32'h2),     0, 0,    0,       0,   1, 9, 6'h40, 32'h1,   32'h2,   1, 0);
    add(1,10, 6'h41, o(6'h0E,0,32'h0),      o(6'h0F,1,32'h0F),    0, 0,    0,       0,   1, 9, 6'h40, 32'h1,   32'h2,   2, 0);
    add(0, 0, 0,     0,                     0,                    1, 6'h0E,32'hEE,  1,   1,10, 6'h41, 32'hEE,  32'h0F,  1, 0);
    add(0, 0, 0,     0,                     0,                    0, 0,    0,       1,   0, 0, 0,     0,       0,       0, 0);

    // reset state
    i_rst = 1'b1;
    drive(1, 4'hF, 6'h3F, o(6'h01,1,32'h1), o(6'h02,1,32'h2), 1, 6'h01, 32'h5, 1);
    repeat (2) @(posedge i_clk);
    #1 check_all("reset", z);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      drive(vt[i].en, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2,
            vt[i].cv, vt[i].ctag, vt[i].cdata, vt[i].iss);
      sb.push_back(vt[i].e);
      @(posedge i_clk);
      #1;
      got = sb.pop_front();
      check_all($sformatf("vec%0d", i), got);
      @(negedge i_clk);
    end

    // asynchronous reset with three entries resident, issue requested
    for (int k = 1; k <= 3; k++) begin
      drive(1, 4'(k), 6'(k + 8), o(6'h01,1,32'(k)), o(6'h02,1,32'(k)), 0, 0, 0, 0);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 check("pre-reset count", 64'(count), 64'd3);
    #1 i_rst = 1'b1;
    #1 check_all("async reset", z);
    @(posedge i_clk);
    #1 check_all("held reset", z);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1, 4'h2, 6'h33, o(6'h01,1,32'hC1), o(6'h02,1,32'hC2), 0, 0, 0, 0);
    sb.push_back('{rdy: 1'b1, op: 4'h2, rd: 6'h33, d1: 32'hC1, d2: 32'hC2, cnt: 3'd1, full: 1'b0});
    @(posedge i_clk);
    #1;
    got = sb.pop_front();
    check_all("post-reset dispatch", got);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries (power of two, >=2).
REQ-002 Parameter: TAG_W, 6, reorder/physical tag width.
REQ-003 Parameter: DATA_W, 32, operand data width.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 dispatch_en  in  1  dispatch request for one integer op this cycle.
REQ-008 dispatch_op  in  4  ALU operation code, stored opaque.
REQ-009 dispatch_rd_tag  in  TAG_W  destination tag.
REQ-010 dispatch_rs1  in  TAG_W+1+DATA_W  packed {tag, valid, data} for operand 1.
REQ-011 dispatch_rs2  in  TAG_W+1+DATA_W  packed {tag, valid, data} for operand 2.
REQ-012 cdb_input  in  TAG_W+1+DATA_W+3  CDB broadcast {tag, valid, data, 3 flag bits}; flags ignored.
REQ-013 issue_int  in  1  issue-unit grant for the integer queue.
REQ-014 ready_int  out  1  at least one entry has both operands valid.
REQ-015 issue_op / issue_rd_tag / issue_rs1_data / issue_rs2_data  out  4/TAG_W/DATA_W/DATA_W  fields of selected entry.
REQ-016 queue_full  out  1  all DEPTH entries occupied.
REQ-017 count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-018 Storage SHALL be a compacting age-ordered queue: entry 0 oldest, occupied entries contiguous from index 0.
REQ-019 Per entry: busy, op, rd_tag, rs1 {tag, valid, data}, rs2 {tag, valid, data}.
REQ-020 Entry ready = busy & rs1.valid & rs2.valid, from registered state only (no same-cycle CDB bypass to ready_int).
REQ-021 Selection: lowest-index ready entry; issue_* outputs combinational from it; outputs zero when ready_int=0.
REQ-022 Issue fires when issue_int & ready_int; selected entry removed at next edge, younger entries shift down by one.
REQ-023 issue_int with ready_int=0 SHALL be ignored, no state change.
REQ-024 Dispatch accepted when dispatch_en & ~queue_full (queue_full from registered count); written to first free slot after any same-cycle removal shift.
REQ-025 Dispatch while queue_full=1 SHALL be dropped, even if issue fires the same cycle.
REQ-026 CDB wakeup: each cycle cdb valid=1, every busy entry operand with valid=0 and tag==cdb tag captures data, sets valid=1 at next edge.
REQ-027 Wakeup applies to entries shifting in the same cycle (value lands in new position).
REQ-028 Dispatch bypass: an incoming operand with valid=0 whose tag equals a valid same-cycle CDB tag SHALL be stored valid with CDB data.
REQ-029 Operands with valid=1 SHALL never be overwritten by the CDB.
REQ-030 count SHALL change by +1 dispatch only, -1 issue only, 0 both or neither; never exceeds DEPTH or wraps below 0.
REQ-031 Latency: dispatched ready op raises ready_int one cycle after dispatch edge; CDB wakeup raises ready_int one cycle after broadcast.

Reset
REQ-032 While i_rst=1: all busy/valid bits 0, count=0, queue_full=0, ready_int=0, issue_* outputs 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately (asynchronous), no issue in that cycle.
REQ-034 First dispatch accepted on first rising edge after i_rst deasserts.

Verification
REQ-035 Dispatch op=3, rd=0x0A, rs1={0x01,1,0x11}, rs2={0x02,1,0x22}, issue_int=0 -> next cycle ready_int=1, issue_rs1_data=0x11, issue_rs2_data=0x22, count=1; issue_int=1 -> count=0, ready_int=0.
REQ-036 Dispatch rs1={0x0B,0,x}; CDB {0x0B,1,0x55} next cycle -> ready_int=1 following cycle, issue_rs1_data=0x55.
REQ-037 Dispatch rs2={0x0C,0,x} in same cycle as CDB {0x0C,1,0x77} -> entry ready one cycle later, issue_rs2_data=0x77.
REQ-038 Fill 4 entries (rd 0x01..0x04), 5th dispatch with queue_full=1 and issue_int=1 -> 5th dropped, count=3, remaining rd order 0x02,0x03,0x04.
REQ-039 Entries rd 0x01 (waiting) and 0x02 (ready) -> issue_rd_tag=0x02; after issue, rd 0x01 moves to entry 0, count=1.
REQ-040 Assert i_rst with 3 entries, mid-cycle -> count=0, ready_int=0 before next edge; dispatch after release accepted normally.
